// File: rtl/riscv_wb.sv
// riscv_wb: write-back stage holding one mem_wb result and committing it to the register file; define RISCV_WB_BYPASS_EN to forward the committing result to rs1/rs2
module riscv_wb #(
  parameter int RF_DEPTH = 32,
  parameter int XLEN = 32,
  parameter int CNT_W = 32,
  localparam int AW = $clog2(RF_DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_wb_rdy,
  output logic             mem_wb_ack,
  input  logic [XLEN-1:0]  mem_wb_data,
  input  logic [AW-1:0]    mem_wb_rd,
  input  logic             wb_stall,
  input  logic [AW-1:0]    rs1_addr,
  output logic [XLEN-1:0]  rs1_data,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs2_data,
  output logic             wb_busy,
  output logic [CNT_W-1:0] retire_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] rf_q [1:RF_DEPTH-1];
  logic [XLEN-1:0] rf_d [1:RF_DEPTH-1];
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic wb_vld, accept, commit;
  always_comb begin
    wb_vld = state_q == FULL;
    mem_wb_ack = !wb_vld || !wb_stall;
    accept = mem_wb_rdy && mem_wb_ack;
    commit = wb_vld && !wb_stall;
    state_d = accept ? FULL : commit ? EMPTY : state_q;
    wb_rd_d = accept ? mem_wb_rd : wb_rd_q;
    wb_data_d = accept ? mem_wb_data : wb_data_q;
    retire_cnt_d = retire_cnt_q + CNT_W'(commit);
    rf_d = rf_q;
    if (commit && wb_rd_q != '0) rf_d[wb_rd_q] = wb_data_q;
  end
  always_comb begin
`ifdef RISCV_WB_BYPASS_EN
    rs1_data = rs1_addr == '0 ? '0 : (commit && rs1_addr == wb_rd_q) ? wb_data_q : rf_q[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : (commit && rs2_addr == wb_rd_q) ? wb_data_q : rf_q[rs2_addr];
`else
    rs1_data = rs1_addr == '0 ? '0 : rf_q[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : rf_q[rs2_addr];
`endif
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      retire_cnt_q <= '0;
      for (int i = 1; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
      retire_cnt_q <= retire_cnt_d;
      rf_q <= rf_d;
    end
  end
  assign wb_busy = wb_vld;
  assign retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_riscv_wb.sv
// tb_riscv_wb: scoreboard bench for riscv_wb; a 4-bit-counter twin instance exercises retire counter wrap
module tb_riscv_wb;
  logic clk = 0, rstn = 0, mem_wb_rdy = 0, wb_stall = 0;
  logic [31:0] mem_wb_data = '0;
  logic [4:0] mem_wb_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic mem_wb_ack, wb_busy, ack_w, busy_w;
  logic [31:0] rs1_data, rs2_data, retire_cnt, rs1_w, rs2_w;
  logic [3:0] retire_cnt_w;
  int n_pass = 0, n_total = 0, exp_retire = 0;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  wb_t sb_q[$];
  wb_t mon_e;
  logic [31:0] exp_rf [32];
  logic [31:0] prev_cnt = '0;
  riscv_wb u_dut (
    .clk(clk), .rstn(rstn), .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(mem_wb_ack),
    .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .wb_stall(wb_stall),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .wb_busy(wb_busy), .retire_cnt(retire_cnt)
  );
  riscv_wb #(.CNT_W(4)) u_dut_w (
    .clk(clk), .rstn(rstn), .mem_wb_rdy(mem_wb_rdy), .mem_wb_ack(ack_w),
    .mem_wb_data(mem_wb_data), .mem_wb_rd(mem_wb_rd), .wb_stall(wb_stall),
    .rs1_addr(rs1_addr), .rs1_data(rs1_w), .rs2_addr(rs2_addr), .rs2_data(rs2_w),
    .wb_busy(busy_w), .retire_cnt(retire_cnt_w)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rstn) begin
      sb_q.delete();
      foreach (exp_rf[i]) exp_rf[i] = '0;
      prev_cnt = '0;
    end else begin
      if (retire_cnt != prev_cnt) begin
        n_total++;
        if (sb_q.size() == 0) $display("FAIL commit_pop: retire_cnt=%0d with empty scoreboard, required an accepted result", retire_cnt);
        else begin
          n_pass++;
          mon_e = sb_q.pop_front();
          if (mon_e.rd != 0) exp_rf[mon_e.rd] = mon_e.data;
        end
      end
      prev_cnt = retire_cnt;
      if (mem_wb_rdy && mem_wb_ack) sb_q.push_back({mem_wb_rd, mem_wb_data});
    end
  end
  task automatic put(input logic [4:0] rd, input logic [31:0] data);
    mem_wb_rdy = 1;
    mem_wb_rd = rd;
    mem_wb_data = data;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %h required %h", name, act, req);
    else n_pass++;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk); #1 put(3, 32'h33);
    @(posedge clk); #1 put(4, 32'h44);
    @(posedge clk); #1 mem_wb_rdy = 0;
    #1 rstn = 0;
    #1;
    n_total++;
    if (mem_wb_ack !== 1'b1) $display("FAIL reset_ack: got %b required 1", mem_wb_ack); else n_pass++;
    n_total++;
    if (wb_busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", wb_busy); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'd0) $display("FAIL reset_retire: got %0d required 0", retire_cnt); else n_pass++;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      n_total++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) $display("FAIL reset_rf[%0d]: rs1=%h rs2=%h required 0", i, rs1_data, rs2_data);
      else n_pass++;
    end
    @(posedge clk); #1 rstn = 1;
    exp_retire = 0;
  endtask
  task automatic test_single;
    @(posedge clk); #1 put(5, 32'hDEADBEEF);
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(negedge clk); #1;
    n_total++;
    if (wb_busy !== 1'b1) $display("FAIL single_busy: got %b required 1", wb_busy); else n_pass++;
    @(posedge clk); #1 rs1_addr = 5;
    exp_retire++;
    @(negedge clk); #1;
    n_total++;
    if (rs1_data !== 32'hDEADBEEF) $display("FAIL single_rf5: got %h required deadbeef", rs1_data); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL single_retire: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
    n_total++;
    if (wb_busy !== 1'b0) $display("FAIL single_idle: got %b required 0", wb_busy); else n_pass++;
  endtask
  task automatic test_x0;
    @(posedge clk); #1 put(0, 32'h12345678);
    rs1_addr = 0;
    rs2_addr = 0;
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(posedge clk); #1;
    exp_retire++;
    @(negedge clk); #1;
    n_total++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) $display("FAIL x0_read: rs1=%h rs2=%h required 0", rs1_data, rs2_data); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL x0_retire: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
  endtask
  task automatic test_back_to_back;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1 put(5'(n), 32'h100 + 32'(n));
      @(negedge clk); #1;
      n_total++;
      if (mem_wb_ack !== 1'b1) $display("FAIL b2b_ack[%0d]: got %b required 1", n, mem_wb_ack); else n_pass++;
    end
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(posedge clk);
    exp_retire += 8;
    @(negedge clk); #1;
    for (int n = 1; n <= 8; n++) begin
      rs1_addr = 5'(n);
      #1;
      n_total++;
      if (rs1_data !== 32'h100 + 32'(n)) $display("FAIL b2b_rf[%0d]: got %h required %h", n, rs1_data, 32'h100 + 32'(n)); else n_pass++;
    end
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL b2b_retire: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
  endtask
  task automatic test_stall;
    @(posedge clk); #1 wb_stall = 1;
    rs1_addr = 9;
    @(negedge clk); #1;
    n_total++;
    if (mem_wb_ack !== 1'b1) $display("FAIL stall_empty_ack: got %b required 1", mem_wb_ack); else n_pass++;
    @(posedge clk); #1 put(9, 32'h900);
    @(posedge clk); #1 put(10, 32'hA00);
    repeat (4) begin
      @(negedge clk); #1;
      n_total++;
      if (mem_wb_ack !== 1'b0) $display("FAIL stall_ack: got %b required 0", mem_wb_ack); else n_pass++;
      n_total++;
      if (wb_busy !== 1'b1) $display("FAIL stall_busy: got %b required 1", wb_busy); else n_pass++;
      n_total++;
      if (retire_cnt !== 32'(exp_retire)) $display("FAIL stall_retire: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
      n_total++;
      if (rs1_data !== 32'd0) $display("FAIL stall_no_write: got %h required 0", rs1_data); else n_pass++;
      @(posedge clk); #1;
    end
    wb_stall = 0;
    @(posedge clk); #1 mem_wb_rdy = 0;
    exp_retire++;
    @(negedge clk); #1;
    n_total++;
    if (rs1_data !== 32'h900) $display("FAIL stall_release_rf9: got %h required 900", rs1_data); else n_pass++;
    n_total++;
    if (wb_busy !== 1'b1) $display("FAIL stall_release_busy: got %b required 1", wb_busy); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL stall_release_retire: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
    @(posedge clk);
    exp_retire++;
    @(negedge clk); #1 rs1_addr = 10;
    #1;
    n_total++;
    if (rs1_data !== 32'hA00) $display("FAIL stall_next_rf10: got %h required a00", rs1_data); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL stall_next_retire: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
  endtask
  task automatic test_bypass;
    logic [31:0] req;
`ifdef RISCV_WB_BYPASS_EN
    req = 32'hA5A5A5A5;
`else
    req = 32'h77;
`endif
    @(posedge clk); #1 put(7, 32'h77);
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(posedge clk); #1 put(7, 32'hA5A5A5A5);
    rs2_addr = 7;
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(negedge clk); #1;
    n_total++;
    if (rs2_data !== req) $display("FAIL bypass_committing: got %h required %h", rs2_data, req); else n_pass++;
    @(posedge clk);
    exp_retire += 2;
    @(negedge clk); #1;
    n_total++;
    if (rs2_data !== 32'hA5A5A5A5) $display("FAIL bypass_after: got %h required a5a5a5a5", rs2_data); else n_pass++;
  endtask
  task automatic test_rf_sweep;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      n_total++;
      if (rs1_data !== exp_rf[i] || rs2_data !== exp_rf[i]) $display("FAIL sweep_rf[%0d]: rs1=%h rs2=%h required %h", i, rs1_data, rs2_data, exp_rf[i]);
      else n_pass++;
    end
    n_total++;
    if (sb_q.size() != 0 || wb_busy !== 1'b0) $display("FAIL sweep_drain: pending=%0d busy=%b required 0/0", sb_q.size(), wb_busy); else n_pass++;
  endtask
  task automatic test_wrap;
    @(posedge clk); #1 rstn = 0;
    @(posedge clk); #1 rstn = 1;
    exp_retire = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 put(5'(i % 31 + 1), $urandom);
    end
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(posedge clk);
    exp_retire = 16;
    @(negedge clk); #1;
    n_total++;
    if (retire_cnt_w !== 4'd0) $display("FAIL wrap_narrow: got %0d required 0", retire_cnt_w); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL wrap_wide: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
    @(posedge clk); #1 put(20, 32'h2020);
    @(posedge clk); #1 mem_wb_rdy = 0;
    @(posedge clk);
    exp_retire++;
    @(negedge clk); #1;
    n_total++;
    if (retire_cnt_w !== 4'd1) $display("FAIL wrap_narrow_next: got %0d required 1", retire_cnt_w); else n_pass++;
    n_total++;
    if (retire_cnt !== 32'(exp_retire)) $display("FAIL wrap_wide_next: got %0d required %0d", retire_cnt, exp_retire); else n_pass++;
    test_rf_sweep();
  endtask
  initial begin
    test_reset();
    test_single();
    test_x0();
    test_back_to_back();
    test_stall();
    test_bypass();
    test_rf_sweep();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
